channel_delay_ctrl: RTL and testbench



---
 rtl/channel_delay_ctrl.sv | 150 +++++++++++++++
 tb/tb_channel_delay_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/channel_delay_ctrl.sv
// Code delay-line controller: owns delay1/delay2, applies new spacings on the delayed epoch, gates corr_en during fill.
// Optional build macro DELAY_ORDER_CHECK_EN discards requests whose delay2 is not strictly greater than delay1.
module channel_delay_ctrl #(
  parameter int DLY_W      = 6,
  parameter int DEPTH      = 129,
  parameter int TIMEOUT    = 65535,
  parameter int RST_DELAY1 = 1,
  parameter int RST_DELAY2 = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart,
  input  logic             dly_epoch,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DLY_W-1:0] req_delay1,
  input  logic [DLY_W-1:0] req_delay2,
  output logic [DLY_W-1:0] delay1,
  output logic [DLY_W-1:0] delay2,
  output logic             corr_en,
  output logic             apply_pulse,
  output logic             timeout_flag,
  output logic             reject_flag,
  input  logic             clr_flags
);

  localparam int FILL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = '1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = '1;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic [FILL_W-1:0] r_fill_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_pend;
  logic [DLY_W-1:0]  r_shadow1;
  logic [DLY_W-1:0]  r_shadow2;
  logic [DLY_W-1:0]  r_delay1;
  logic [DLY_W-1:0]  r_delay2;
  logic              r_apply_pulse;
  logic              r_timeout_flag;

  logic w_in_run;
  logic w_accept;
  logic w_reject;
  logic w_take;
  logic w_to_hit;
  logic w_apply;

  assign w_in_run = (r_state == ST_RUN);
  assign w_accept = req_valid & ~r_pend;

`ifdef DELAY_ORDER_CHECK_EN
  assign w_reject = w_accept & (req_delay2 <= req_delay1);
`else
  assign w_reject = 1'b0;
`endif

  assign w_take   = w_accept & ~w_reject;
  assign w_to_hit = r_pend & w_in_run & (r_to_cnt == TO_LAST);
  // During fill the delay-line output is invalid anyway, so a pending request goes in immediately.
  assign w_apply  = r_pend & (~w_in_run | dly_epoch | w_to_hit);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_FILL;
      r_fill_cnt <= '0;
    end else if (restart) begin
      r_state    <= ST_FILL;
      r_fill_cnt <= '0;
    end else if (r_state == ST_FILL) begin
      if (r_fill_cnt == FILL_LAST) begin
        r_state <= ST_RUN;
      end
      if (r_fill_cnt != FILL_MAX) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend        <= 1'b0;
      r_to_cnt      <= '0;
      r_shadow1     <= DLY_W'(RST_DELAY1);
      r_shadow2     <= DLY_W'(RST_DELAY2);
      r_delay1      <= DLY_W'(RST_DELAY1);
      r_delay2      <= DLY_W'(RST_DELAY2);
      r_apply_pulse <= 1'b0;
    end else begin
      r_apply_pulse <= w_apply;
      if (w_apply) begin
        r_delay1 <= r_shadow1;
        r_delay2 <= r_shadow2;
        r_pend   <= 1'b0;
        r_to_cnt <= '0;
      end else if (w_take) begin
        r_shadow1 <= req_delay1;
        r_shadow2 <= req_delay2;
        r_pend    <= 1'b1;
        r_to_cnt  <= '0;
      end else if (r_pend && w_in_run && (r_to_cnt != TO_MAX)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // Sticky flags: a new set event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_timeout_flag <= 1'b0;
    end else if (w_to_hit) begin
      r_timeout_flag <= 1'b1;
    end else if (clr_flags) begin
      r_timeout_flag <= 1'b0;
    end
  end

`ifdef DELAY_ORDER_CHECK_EN
  logic r_reject_flag;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_reject_flag <= 1'b0;
    end else if (w_reject) begin
      r_reject_flag <= 1'b1;
    end else if (clr_flags) begin
      r_reject_flag <= 1'b0;
    end
  end

  assign reject_flag = r_reject_flag;
`else
  assign reject_flag = 1'b0;
`endif

  assign req_ready    = ~r_pend;
  assign delay1       = r_delay1;
  assign delay2       = r_delay2;
  assign corr_en      = w_in_run;
  assign apply_pulse  = r_apply_pulse;
  assign timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_channel_delay_ctrl.sv
// Self-checking bench for channel_delay_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_channel_delay_ctrl;

  localparam int DLY_W   = 6;
  localparam int DEPTH   = 129;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             restart;
  logic             dly_epoch;
  logic             req_valid;
  logic             req_ready;
  logic [DLY_W-1:0] req_delay1;
  logic [DLY_W-1:0] req_delay2;
  logic [DLY_W-1:0] delay1;
  logic [DLY_W-1:0] delay2;
  logic             corr_en;
  logic             apply_pulse;
  logic             timeout_flag;
  logic             reject_flag;
  logic             clr_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  channel_delay_ctrl #(
    .DLY_W(DLY_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .RST_DELAY1(1), .RST_DELAY2(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .dly_epoch(dly_epoch),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_delay1(req_delay1), .req_delay2(req_delay2),
    .delay1(delay1), .delay2(delay2), .corr_en(corr_en),
    .apply_pulse(apply_pulse), .timeout_flag(timeout_flag),
    .reject_flag(reject_flag), .clr_flags(clr_flags)
  );

  // Reference model: edges since fill start, one pending slot with its age, applied delays, flags.
  int               m_fill;
  bit               m_pend;
  int               m_age;
  logic [DLY_W-1:0] m_sh1, m_sh2, m_d1, m_d2;
  bit               m_pulse, m_tflag, m_rflag;

  task automatic model_edge();
    bit running, forced, apply, accept, reject;
    if (!reset_n) begin
      m_fill = 0; m_pend = 0; m_age = 0;
      m_d1 = 6'd1; m_d2 = 6'd2;
      m_pulse = 0; m_tflag = 0; m_rflag = 0;
      return;
    end
    running = (m_fill >= DEPTH);
    forced  = m_pend && running && (m_age == TIMEOUT - 1);
    apply   = m_pend && (!running || dly_epoch || forced);
    accept  = req_valid && !m_pend;
    reject  = 0;
`ifdef DELAY_ORDER_CHECK_EN
    reject  = accept && (req_delay2 <= req_delay1);
`endif
    m_pulse = apply;
    if (apply) begin
      m_d1 = m_sh1; m_d2 = m_sh2; m_pend = 0; m_age = 0;
    end else if (accept && !reject) begin
      m_sh1 = req_delay1; m_sh2 = req_delay2; m_pend = 1; m_age = 0;
    end else if (m_pend && running) begin
      m_age = m_age + 1;
    end
    if (forced) m_tflag = 1;
    else if (clr_flags) m_tflag = 0;
    if (reject) m_rflag = 1;
    else if (clr_flags) m_rflag = 0;
    m_fill = restart ? 0 : ((m_fill < DEPTH) ? m_fill + 1 : DEPTH);
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_val("corr_en",      32'(corr_en),      32'(m_fill >= DEPTH));
    check_val("delay1",       32'(delay1),       32'(m_d1));
    check_val("delay2",       32'(delay2),       32'(m_d2));
    check_val("apply_pulse",  32'(apply_pulse),  32'(m_pulse));
    check_val("req_ready",    32'(req_ready),    32'(!m_pend));
    check_val("timeout_flag", 32'(timeout_flag), 32'(m_tflag));
    check_val("reject_flag",  32'(reject_flag),  32'(m_rflag));
  endtask

  task automatic drive(input bit rn, input bit rs, input bit ep, input bit v,
                       input int d1, input int d2, input bit clr);
    reset_n = rn; restart = rs; dly_epoch = ep; req_valid = v;
    req_delay1 = DLY_W'(d1); req_delay2 = DLY_W'(d2); clr_flags = clr;
  endtask

  task automatic idle(input int n);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();

    // Reset release and fill time.
    idle(DEPTH - 1);
    check_val("fill_edge_128", 32'(corr_en), 32'd0);
    check_val("rst_delay1", 32'(delay1), 32'd1);
    check_val("rst_delay2", 32'(delay2), 32'd2);
    check_val("rst_ready", 32'(req_ready), 32'd1);
    idle(1);
    check_val("fill_edge_129", 32'(corr_en), 32'd1);

    // Request (5,9), second request while pending ignored, apply on epoch.
    drive(1, 0, 0, 1, 5, 9, 0); tick();
    check_val("req_busy", 32'(req_ready), 32'd0);
    idle(4);
    drive(1, 0, 0, 1, 1, 2, 0); tick();
    idle(5);
    drive(1, 0, 1, 0, 0, 0, 0); tick();
    check_val("apply_59", 32'(apply_pulse), 32'd1);
    check_val("d1_5", 32'(delay1), 32'd5);
    check_val("d2_9", 32'(delay2), 32'd9);
    idle(1);
    check_val("ready_back", 32'(req_ready), 32'd1);
    check_val("pulse_one_cycle", 32'(apply_pulse), 32'd0);

    // Accept coincident with epoch: no apply until the following epoch.
    drive(1, 0, 1, 1, 12, 20, 0); tick();
    check_val("coinc_no_apply", 32'(apply_pulse), 32'd0);
    check_val("coinc_d1_kept", 32'(delay1), 32'd5);
    idle(10);
    drive(1, 0, 1, 0, 0, 0, 0); tick();
    check_val("coinc_apply", 32'(apply_pulse), 32'd1);
    check_val("coinc_d1", 32'(delay1), 32'd12);
    check_val("coinc_d2", 32'(delay2), 32'd20);

    // Forced apply after TIMEOUT cycles without an epoch.
    drive(1, 0, 0, 1, 6, 30, 0); tick();
    idle(TIMEOUT - 1);
    check_val("to_not_yet", 32'(timeout_flag), 32'd0);
    idle(1);
    check_val("to_apply", 32'(apply_pulse), 32'd1);
    check_val("to_flag", 32'(timeout_flag), 32'd1);
    check_val("to_d2", 32'(delay2), 32'd30);
    drive(1, 0, 0, 0, 0, 0, 1); tick();
    check_val("to_cleared", 32'(timeout_flag), 32'd0);
    drive(1, 0, 0, 1, 2, 40, 0); tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(1, 0, 0, 0, 0, 0, i == TIMEOUT - 1);
      tick();
    end
    check_val("to_set_wins", 32'(timeout_flag), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 1); tick();

    // Restart mid-run with (3,7) pending.
    drive(1, 0, 0, 1, 3, 7, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    check_val("rs_corr_off", 32'(corr_en), 32'd0);
    idle(1);
    check_val("rs_apply", 32'(apply_pulse), 32'd1);
    check_val("rs_d1", 32'(delay1), 32'd3);
    check_val("rs_d2", 32'(delay2), 32'd7);
    idle(DEPTH - 2);
    check_val("rs_fill_128", 32'(corr_en), 32'd0);
    idle(1);
    check_val("rs_fill_129", 32'(corr_en), 32'd1);

    // Out-of-order request (8,4).
    drive(1, 0, 0, 1, 8, 4, 0); tick();
    idle(3);
    drive(1, 0, 1, 0, 0, 0, 0); tick();
`ifdef DELAY_ORDER_CHECK_EN
    check_val("ord_reject", 32'(reject_flag), 32'd1);
    check_val("ord_no_pulse", 32'(apply_pulse), 32'd0);
    check_val("ord_d1", 32'(delay1), 32'd3);
    check_val("ord_d2", 32'(delay2), 32'd7);
`else
    check_val("ord_reject", 32'(reject_flag), 32'd0);
    check_val("ord_pulse", 32'(apply_pulse), 32'd1);
    check_val("ord_d1", 32'(delay1), 32'd8);
    check_val("ord_d2", 32'(delay2), 32'd4);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(1499) != 0),
            ($urandom_range(399) == 0),
            ($urandom_range(7) == 0),
            ($urandom_range(2) == 0),
            int'($urandom_range(63)), int'($urandom_range(63)),
            ($urandom_range(9) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
